// File: rtl/inc_pkg.sv
// Shared encodings and default sizing for the increment-request pulser.
package inc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned PEND_W_DEF     = 3;
    localparam int unsigned GAP_CYCLES_DEF = 2;

endpackage

// File: rtl/inc_req_edge.sv
// Rising-edge detector for the request line; INC_REQ_SYNC_EN adds a 2-flop
// synchronizer in front so req may be asynchronous to clk.
module inc_req_edge
    import inc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic req_evt
);

    logic req_s;
    logic req_r1;
    logic req_r2;

`ifdef INC_REQ_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= req;
            sync_q2 <= sync_q1;
        end
    end

    assign req_s = sync_q2;
`else
    assign req_s = req;
`endif

    // Edge regs clear on reset, so a req already high at release is one request.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r1 <= 1'b0;
            req_r2 <= 1'b0;
        end else begin
            req_r1 <= req_s;
            req_r2 <= req_r1;
        end
    end

    assign req_evt = req_r1 & ~req_r2;

endmodule

// File: rtl/inc_req_pulser.sv
// Turns request edges into spaced one-cycle increment strobes with a saturating
// pending buffer and sticky overflow. INC_REQ_SYNC_EN enables the req synchronizer.
module inc_req_pulser
    import inc_pkg::*;
#(
    parameter int unsigned PEND_W     = PEND_W_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ovf_clr,
    output logic              increment,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned GAP_W = (GAP_CYCLES != 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              inc_q, inc_d;
    logic              req_evt;
    logic              ready;
    logic              dec;
    logic              bypass;
    logic              accept;
    logic              ovf_set;

    inc_req_edge u_edge (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_evt (req_evt)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        ready   = 1'b0;
        dec     = 1'b0;
        bypass  = 1'b0;
        ovf_set = 1'b0;

        unique case (state_q)
            IDLE: ready = 1'b1;
            PULSE: begin
                if (GAP_CYCLES != 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    ready = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    ready = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Launch decision is taken on the last gap cycle so the strobe period is 1+GAP_CYCLES.
        if (ready) begin
            state_d = IDLE;
            if (pend_q != '0) begin
                state_d = PULSE;
                dec     = 1'b1;
            end else if (req_evt) begin
                state_d = PULSE;
                bypass  = 1'b1;
            end
        end

        accept = req_evt & ~bypass;
        if (accept && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!accept && dec) begin
            pend_d = pend_q - 1'b1;
        end

        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        inc_d = (state_d == PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            inc_q   <= inc_d;
        end
    end

    assign increment = inc_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE) || (pend_q != '0);

endmodule
